// File: rtl/rv32i_mmio_pkg.sv
// Shared definitions for MMIO responders on the RV32I data bus: register word indices,
// control/status bit positions and the byte-lane merge helper.
package rv32i_mmio_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_COUNT   = 3'd1;
    localparam logic [2:0] REG_COMPARE = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_CAPTURE = 3'd4;

    localparam int unsigned CTRL_EN          = 0;
    localparam int unsigned CTRL_AUTO_RELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN      = 2;
    localparam int unsigned CTRL_PS_LSB      = 8;
    localparam int unsigned CTRL_PS_MSB      = 15;
    localparam logic [31:0] CTRL_MASK        = 32'h0000_FF07;

    localparam int unsigned STAT_MATCH = 0;
    localparam int unsigned STAT_OVF   = 1;

    function automatic logic [31:0] be_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rv32i_mmio_timer_prescaler.sv
// Prescaler for the MMIO timer: an 8-bit counter that emits one tick every PRESCALE+1 enabled
// cycles and can be restarted from the register file.
module timer_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] prescale,
    input  logic       clr,
    output logic       tick
);

    logic [7:0] pcnt_q, pcnt_d;

    assign tick = en & (pcnt_q == prescale);

    // A restart takes priority over a tick that fires under the old settings.
    always_comb begin
        pcnt_d = pcnt_q;
        if (clr) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = pcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/rv32i_mmio_timer.sv
// Memory-mapped prescaled timer with compare, capture and sticky match/overflow flags,
// answering the CPU data port with same-cycle read data.
module rv32i_mmio_timer
    import rv32i_mmio_pkg::*;
#(
    parameter int unsigned ADDR_W        = 5,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [31:0]       MemWData,
    input  logic [3:0]        ByteEnable,
    output logic [31:0]       MemRData,
    output logic              irq
);

    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] capture_q, capture_d;
    logic        match_q, match_d;
    logic        ovf_q, ovf_d;

    logic [2:0]  sel;
    logic        wr;
    logic        wr_ctrl, wr_count, wr_compare, wr_status;
    logic [31:0] ctrl_wdata;
    logic        ps_clr;
    logic        tick;
    logic        set_match, set_ovf;
    logic        clr_match, clr_ovf;
    logic        unused_addr;

    assign sel         = MemAddr[4:2];
    assign unused_addr = ^MemAddr[1:0];

    // ByteEnable=0000 is treated as no write at all, so it cannot pre-empt a tick.
    assign wr         = cs & MemWrite & (|ByteEnable);
    assign wr_ctrl    = wr & (sel == REG_CTRL);
    assign wr_count   = wr & (sel == REG_COUNT);
    assign wr_compare = wr & (sel == REG_COMPARE);
    assign wr_status  = wr & (sel == REG_STATUS);

    assign ctrl_wdata = be_merge(ctrl_q, MemWData, ByteEnable) & CTRL_MASK;
    assign ps_clr     = wr_ctrl &
                        ((ctrl_wdata[CTRL_PS_MSB:CTRL_PS_LSB] != ctrl_q[CTRL_PS_MSB:CTRL_PS_LSB]) |
                         (ctrl_wdata[CTRL_EN] & ~ctrl_q[CTRL_EN]));

    timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (ctrl_q[CTRL_EN]),
        .prescale (ctrl_q[CTRL_PS_MSB:CTRL_PS_LSB]),
        .clr      (ps_clr),
        .tick     (tick)
    );

    // A CPU write to COUNT wins over the tick and suppresses match/overflow for that cycle.
    always_comb begin
        count_d   = count_q;
        capture_d = capture_q;
        set_match = 1'b0;
        set_ovf   = 1'b0;
        if (wr_count) begin
            count_d = be_merge(count_q, MemWData, ByteEnable);
        end else if (tick) begin
            if (count_q == compare_q) begin
                set_match = 1'b1;
                capture_d = count_q;
                count_d   = ctrl_q[CTRL_AUTO_RELOAD] ? '0 : count_q + 32'd1;
            end else if (count_q == 32'hFFFF_FFFF) begin
                set_ovf = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_comb begin
        ctrl_d    = wr_ctrl ? ctrl_wdata : ctrl_q;
        compare_d = wr_compare ? be_merge(compare_q, MemWData, ByteEnable) : compare_q;
        clr_match = wr_status & ByteEnable[0] & MemWData[STAT_MATCH];
        clr_ovf   = wr_status & ByteEnable[0] & MemWData[STAT_OVF];
        // Hardware set beats a same-cycle W1C.
        match_d   = set_match | (match_q & ~clr_match);
        ovf_d     = set_ovf | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= RESET_COMPARE;
            capture_q <= '0;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            capture_q <= capture_d;
            match_q   <= match_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        MemRData = '0;
        if (cs & ~MemWrite) begin
            case (sel)
                REG_CTRL:    MemRData = ctrl_q;
                REG_COUNT:   MemRData = count_q;
                REG_COMPARE: MemRData = compare_q;
                REG_STATUS:  MemRData = {30'd0, ovf_q, match_q};
                REG_CAPTURE: MemRData = capture_q;
                default:     MemRData = '0;
            endcase
        end
    end

    assign irq = ctrl_q[CTRL_IRQ_EN] & (match_q | ovf_q);

endmodule

// File: tb/tb_rv32i_mmio_timer.sv
// Scoreboard bench for rv32i_mmio_timer: directed scenarios plus random bus traffic, checked
// against a register-level reference model of the timer.
module tb_rv32i_mmio_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0;
    logic        MemWrite = 1'b0;
    logic [4:0]  MemAddr = '0;
    logic [31:0] MemWData = '0;
    logic [3:0]  ByteEnable = '0;
    logic [31:0] MemRData;
    logic        irq;

    always #5 clk = ~clk;

    rv32i_mmio_timer #(
        .ADDR_W        (5),
        .RESET_COMPARE (32'hFFFF_FFFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .MemWrite   (MemWrite),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .ByteEnable (ByteEnable),
        .MemRData   (MemRData),
        .irq        (irq)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: the architectural registers only.
    logic [31:0] m_ctrl = '0;
    logic [31:0] m_count = '0;
    logic [31:0] m_cmp = 32'hFFFF_FFFF;
    logic [31:0] m_cap = '0;
    logic        m_match = 1'b0;
    logic        m_ovf = 1'b0;
    int          m_pcnt = 0;

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a[4:2])
            3'd0:    return m_ctrl;
            3'd1:    return m_count;
            3'd2:    return m_cmp;
            3'd3:    return {30'd0, m_ovf, m_match};
            3'd4:    return m_cap;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_irq();
        return m_ctrl[2] && (m_match || m_ovf);
    endfunction

    // Advance the model across one rising edge using the inputs presented in that cycle.
    task automatic model_edge();
        logic [31:0] nc;
        logic        tick, wr, sm, so;
        int          w;
        if (!reset) begin
            m_ctrl = '0; m_count = '0; m_cmp = 32'hFFFF_FFFF; m_cap = '0;
            m_match = 1'b0; m_ovf = 1'b0; m_pcnt = 0;
            return;
        end
        tick = m_ctrl[0] && (m_pcnt == int'(m_ctrl[15:8]));
        wr   = cs && MemWrite && (ByteEnable != 4'd0);
        w    = int'(MemAddr[4:2]);
        sm   = 1'b0;
        so   = 1'b0;
        nc   = (wr && w == 0) ? (lanes(m_ctrl, MemWData, ByteEnable) & 32'h0000_FF07) : m_ctrl;
        if (wr && w == 0 && (nc[15:8] != m_ctrl[15:8] || (nc[0] && !m_ctrl[0]))) m_pcnt = 0;
        else if (tick) m_pcnt = 0;
        else if (m_ctrl[0]) m_pcnt = m_pcnt + 1;
        if (wr && w == 1) begin
            m_count = lanes(m_count, MemWData, ByteEnable);
        end else if (tick) begin
            if (m_count == m_cmp) begin
                sm = 1'b1;
                m_cap = m_count;
                m_count = m_ctrl[1] ? 32'd0 : m_count + 32'd1;
            end else if (m_count == 32'hFFFF_FFFF) begin
                so = 1'b1;
                m_count = 32'd0;
            end else begin
                m_count = m_count + 32'd1;
            end
        end
        if (wr && w == 3 && ByteEnable[0]) begin
            if (MemWData[0]) m_match = 1'b0;
            if (MemWData[1]) m_ovf = 1'b0;
        end
        if (sm) m_match = 1'b1;
        if (so) m_ovf = 1'b1;
        if (wr && w == 2) m_cmp = lanes(m_cmp, MemWData, ByteEnable);
        m_ctrl = nc;
    endtask

    task automatic drive(input logic rst_n, input logic c, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] be, input logic use_k,
                         input logic [31:0] k, input logic k_irq);
        exp_t e;
        reset = rst_n; cs = c; MemWrite = we; MemAddr = a; MemWData = d; ByteEnable = be;
        if (c && !we) begin
            e.addr = a;
            e.data = use_k ? k : m_read(a);
            e.irq  = use_k ? k_irq : m_irq();
            exp_q.push_back(e);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        drive(1'b1, 1'b1, 1'b1, a, d, be, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic rd(input logic [4:0] a);
        drive(1'b1, 1'b1, 1'b0, a, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic rdk(input logic [4:0] a, input logic [31:0] k, input logic ki);
        drive(1'b1, 1'b1, 1'b0, a, 32'd0, 4'd0, 1'b1, k, ki);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic rst_cyc();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0);
    endtask

    // Monitor: every read presented on the bus pops one expectation; other cycles must read 0.
    always @(negedge clk) begin
        exp_t e;
        if (cs && !MemWrite) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd-unexpected addr=%h got data=%h irq=%b want nothing queued",
                         MemAddr, MemRData, irq);
            end else begin
                e = exp_q.pop_front();
                if (MemRData !== e.data || irq !== e.irq) begin
                    n_err++;
                    $display("FAIL rd@%h t=%0t got data=%h irq=%b want data=%h irq=%b",
                             e.addr, $time, MemRData, irq, e.data, e.irq);
                end
            end
        end else begin
            n_vec++;
            if (MemRData !== 32'd0 || irq !== m_irq()) begin
                n_err++;
                $display("FAIL no-read t=%0t got data=%h irq=%b want data=00000000 irq=%b",
                         $time, MemRData, irq, m_irq());
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic [4:0]  a;
        logic [3:0]  be;
        int          r;

        // Reset and reset values.
        rst_cyc();
        rst_cyc();
        rdk(5'h00, 32'h0, 1'b0);
        rdk(5'h04, 32'h0, 1'b0);
        rdk(5'h08, 32'hFFFF_FFFF, 1'b0);
        rdk(5'h0C, 32'h0, 1'b0);
        rdk(5'h10, 32'h0, 1'b0);
        rdk(5'h18, 32'h0, 1'b0);

        // Byte lanes.
        wr(5'h08, 32'h1122_3344, 4'b1111);
        wr(5'h08, 32'hAABB_CCDD, 4'b0100);
        rdk(5'h08, 32'h11BB_3344, 1'b0);

        // Match with auto-reload, then W1C.
        wr(5'h08, 32'd3, 4'b1111);
        wr(5'h00, 32'h0000_0007, 4'b1111);
        rdk(5'h04, 32'd0, 1'b0);
        rdk(5'h04, 32'd1, 1'b0);
        rdk(5'h04, 32'd2, 1'b0);
        rdk(5'h04, 32'd3, 1'b0);
        rdk(5'h04, 32'd0, 1'b1);
        rdk(5'h10, 32'd3, 1'b1);
        wr(5'h00, 32'h0000_0006, 4'b1111);
        wr(5'h0C, 32'd1, 4'b1111);
        rdk(5'h0C, 32'd0, 1'b0);
        rdk(5'h04, 32'd3, 1'b0);

        // Prescale 2 and overflow.
        wr(5'h08, 32'd5, 4'b1111);
        wr(5'h04, 32'hFFFF_FFFE, 4'b1111);
        wr(5'h00, 32'h0000_0205, 4'b1111);
        for (int i = 0; i < 3; i++) rdk(5'h04, 32'hFFFF_FFFE, 1'b0);
        for (int i = 0; i < 3; i++) rdk(5'h04, 32'hFFFF_FFFF, 1'b0);
        rdk(5'h04, 32'd0, 1'b1);
        rdk(5'h0C, 32'd2, 1'b1);

        // COUNT write in a tick cycle, full and partial.
        wr(5'h0C, 32'd3, 4'b1111);
        wr(5'h00, 32'h0000_0005, 4'b1111);
        wr(5'h04, 32'h0000_0100, 4'b1111);
        rdk(5'h04, 32'h0000_0100, 1'b0);
        wr(5'h04, 32'h0000_0055, 4'b0001);
        rdk(5'h04, 32'h0000_0155, 1'b0);

        // W1C of MATCH in the same cycle as a new match.
        wr(5'h08, 32'h0000_0200, 4'b1111);
        wr(5'h04, 32'h0000_01FF, 4'b1111);
        rdk(5'h04, 32'h0000_01FF, 1'b0);
        wr(5'h0C, 32'd1, 4'b1111);
        rdk(5'h0C, 32'd1, 1'b1);

        // Mid-operation reset.
        rst_cyc();
        rdk(5'h00, 32'h0, 1'b0);
        rdk(5'h04, 32'h0, 1'b0);
        rdk(5'h08, 32'hFFFF_FFFF, 1'b0);
        rdk(5'h0C, 32'h0, 1'b0);
        rdk(5'h10, 32'h0, 1'b0);
        rdk(5'h04, 32'h0, 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                rst_cyc();
            end else if (r < 12) begin
                drive(1'b1, 1'b0, 1'($urandom), 5'($urandom), $urandom, 4'($urandom),
                      1'b0, 32'd0, 1'b0);
            end else if (r < 55) begin
                rd(5'($urandom));
            end else begin
                a  = 5'($urandom);
                d  = $urandom;
                be = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom);
                case (a[4:2])
                    3'd0: begin
                        d[15:8] = 8'($urandom_range(0, 3));
                        d[0]    = ($urandom_range(0, 3) != 0);
                    end
                    3'd1: begin
                        case ($urandom_range(0, 2))
                            0:       d = m_cmp - 32'($urandom_range(0, 6));
                            1:       d = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
                            default: d = $urandom;
                        endcase
                    end
                    3'd2: if ($urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 40));
                    default: ;
                endcase
                wr(a, d, be);
            end
        end

        idle();
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard-drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
